alu_op_issuer: RTL

ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

---
 rtl/alu_op_issuer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: command FIFO feeding an external combinational 4-bit ALU,
// with a single registered result stage and valid/ready on both sides.
// Optional build macro: ALU_ISSUE_OPCHECK_EN (rejects opcodes 11..15 at issue,
// reporting them through out_err instead of forwarding the ALU response).
module alu_op_issuer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_operand_a,
    input  logic [3:0]                 in_operand_b,
    input  logic [3:0]                 in_opcode,
    output logic [3:0]                 alu_operand_a,
    output logic [3:0]                 alu_operand_b,
    output logic [3:0]                 alu_opcode,
    input  logic [3:0]                 alu_result,
    input  logic                       alu_carry_out,
    input  logic                       alu_overflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_result,
    output logic                       out_carry,
    output logic                       out_overflow,
    output logic                       out_err,
    output logic [3:0]                 out_opcode,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [7:0]                 done_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Entry layout: {opcode, operand_b, operand_a}
    logic [11:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          out_valid_q;
    logic [3:0]    out_result_q, out_opcode_q;
    logic          out_carry_q, out_overflow_q, out_err_q;
    logic [7:0]    done_q;

    logic          has_head, push, issue, consume;
    logic [11:0]   head;
`ifdef ALU_ISSUE_OPCHECK_EN
    logic          bad_op;
`endif

    assign has_head = (count_q != '0);
    assign head     = mem_q[rd_ptr_q];
    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    // Result stage is free when empty or being drained this same edge
    assign issue    = has_head && (!out_valid_q || out_ready);
    assign consume  = out_valid_q && out_ready;

    // ALU is driven straight from the FIFO head; idle bus is all zero
    always_comb begin
        alu_operand_a = '0;
        alu_operand_b = '0;
        alu_opcode    = '0;
`ifdef ALU_ISSUE_OPCHECK_EN
        bad_op        = 1'b0;
`endif
        if (has_head) begin
            alu_operand_a = head[3:0];
            alu_operand_b = head[7:4];
            alu_opcode    = head[11:8];
`ifdef ALU_ISSUE_OPCHECK_EN
            if (head[11:8] >= 4'd11) begin
                bad_op     = 1'b1;
                alu_opcode = '0;
            end
`endif
        end
    end

    // FIFO storage needs no reset: only entries between the pointers are read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_opcode, in_operand_b, in_operand_a};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + AW'(1);
            if (issue) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, issue})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Result register: loads on issue, otherwise clears valid when drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_result_q   <= '0;
            out_carry_q    <= 1'b0;
            out_overflow_q <= 1'b0;
            out_err_q      <= 1'b0;
            out_opcode_q   <= '0;
        end else if (issue) begin
            out_valid_q    <= 1'b1;
            out_opcode_q   <= head[11:8];
`ifdef ALU_ISSUE_OPCHECK_EN
            out_result_q   <= bad_op ? 4'd0 : alu_result;
            out_carry_q    <= bad_op ? 1'b0 : alu_carry_out;
            out_overflow_q <= bad_op ? 1'b0 : alu_overflow;
            out_err_q      <= bad_op;
`else
            out_result_q   <= alu_result;
            out_carry_q    <= alu_carry_out;
            out_overflow_q <= alu_overflow;
            out_err_q      <= 1'b0;
`endif
        end else if (consume) begin
            out_valid_q    <= 1'b0;
        end
    end

    // Completed-handshake counter, free-running modulo 256
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          done_q <= '0;
        else if (consume) done_q <= done_q + 8'd1;
    end

    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_carry    = out_carry_q;
    assign out_overflow = out_overflow_q;
    assign out_err      = out_err_q;
    assign out_opcode   = out_opcode_q;
    assign fifo_count   = count_q;
    assign done_count   = done_q;
endmodule
